nano_imem_loader: RTL and testbench

NANO_IMEM_LOADER -- requirements
Module: nano_imem_loader

---
 rtl/nano_imem_loader_pkg.sv | 16 +
 rtl/nano_imem_ram.sv | 25 ++
 rtl/nano_imem_loader.sv | 129 ++++++++++++
 tb/tb_nano_imem_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encodings, the NOP
// word and the default memory depth.
package nano_imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_RUN  = 3'd4
    } state_e;

    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH = 256;

endpackage

// File: rtl/nano_imem_ram.sv
// Instruction storage: DEPTH x 32, synchronous write, asynchronous read.
// Deliberately not reset; contents survive core resets and partial loads.
module nano_imem_ram #(
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/nano_imem_loader.sv
// Byte-stream program loader: receives a 16-bit word count and little-endian
// words, fills instruction memory, then releases the core and serves fetches.
//
// state | meaning
// IDLE  | after reset, core held in reset, loader not ready
// LEN0  | waiting for word count low byte
// LEN1  | waiting for word count high byte
// DATA  | assembling 4-byte words and writing them to memory
// RUN   | core released, instructions served from memory
module nano_imem_loader
    import nano_imem_loader_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc,
    output logic [31:0] o_inst,
    output logic        o_core_rst,
    input  logic        i_ld_start,
    input  logic        i_ld_valid,
    input  logic [7:0]  i_ld_data,
    output logic        o_ld_ready,
    output logic        o_ld_err,
    output logic [2:0]  o_state
);

    state_e      state, state_d;
    logic [15:0] len, len_d;
    logic [1:0]  byte_cnt, byte_cnt_d;
    logic [16:0] word_idx, word_idx_d;
    logic [23:0] word_buf, word_buf_d;
    logic        ld_err, ld_err_d;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        accept;

    assign o_ld_ready = (state == ST_LEN0) || (state == ST_LEN1) || (state == ST_DATA);
    assign accept     = i_ld_valid && o_ld_ready;
    assign wr_data    = {i_ld_data, word_buf};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            len      <= '0;
            byte_cnt <= '0;
            word_idx <= '0;
            word_buf <= '0;
            ld_err   <= 1'b0;
        end else begin
            state    <= state_d;
            len      <= len_d;
            byte_cnt <= byte_cnt_d;
            word_idx <= word_idx_d;
            word_buf <= word_buf_d;
            ld_err   <= ld_err_d;
        end
    end

    always_comb begin
        state_d    = state;
        len_d      = len;
        byte_cnt_d = byte_cnt;
        word_idx_d = word_idx;
        word_buf_d = word_buf;
        ld_err_d   = ld_err;
        wr_en      = 1'b0;

        // Start wins over any byte accepted on the same edge.
        if (i_ld_start) begin
            state_d    = ST_LEN0;
            len_d      = '0;
            byte_cnt_d = '0;
            word_idx_d = '0;
            ld_err_d   = 1'b0;
        end else if (accept) begin
            unique case (state)
                ST_LEN0: begin
                    len_d[7:0] = i_ld_data;
                    state_d    = ST_LEN1;
                end
                ST_LEN1: begin
                    len_d[15:8] = i_ld_data;
                    state_d     = ({i_ld_data, len[7:0]} != 16'd0) ? ST_DATA : ST_RUN;
                end
                ST_DATA: begin
                    byte_cnt_d = byte_cnt + 2'd1;
                    unique case (byte_cnt)
                        2'd0: word_buf_d[7:0]   = i_ld_data;
                        2'd1: word_buf_d[15:8]  = i_ld_data;
                        2'd2: word_buf_d[23:16] = i_ld_data;
                        default: begin
                            // Overflow words are still consumed so the stream stays aligned.
                            if (word_idx < 17'(DEPTH)) begin
                                wr_en = 1'b1;
                            end else begin
                                ld_err_d = 1'b1;
                            end
                            word_idx_d = word_idx + 17'd1;
                            if ((word_idx + 17'd1) == {1'b0, len}) begin
                                state_d = ST_RUN;
                            end
                        end
                    endcase
                end
                default: state_d = state;
            endcase
        end
    end

    nano_imem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (wr_en),
        .i_waddr (word_idx[AW-1:0]),
        .i_wdata (wr_data),
        .i_raddr (i_pc[AW-1:0]),
        .o_rdata (rd_data)
    );

    assign o_inst     = ((state == ST_RUN) && (i_pc < 32'(DEPTH))) ? rd_data : NOP_INST;
    assign o_core_rst = (state != ST_RUN);
    assign o_ld_err   = ld_err;
    assign o_state    = state;

endmodule

// File: tb/tb_nano_imem_loader.sv
// Directed bench for nano_imem_loader: a DEPTH=256 and a DEPTH=4 instance share
// the same stimulus so overflow behaviour can be compared side by side.
module tb_nano_imem_loader;

    localparam logic [2:0]  S_IDLE = 3'd0;
    localparam logic [2:0]  S_LEN0 = 3'd1;
    localparam logic [2:0]  S_LEN1 = 3'd2;
    localparam logic [2:0]  S_DATA = 3'd3;
    localparam logic [2:0]  S_RUN  = 3'd4;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_pc;
    logic        i_ld_start;
    logic        i_ld_valid;
    logic [7:0]  i_ld_data;

    logic [31:0] inst_b, inst_s;
    logic        core_rst_b, core_rst_s;
    logic        ready_b, ready_s;
    logic        err_b, err_s;
    logic [2:0]  state_b, state_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    nano_imem_loader #(.DEPTH(256)) u_big (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_pc       (i_pc),
        .o_inst     (inst_b),
        .o_core_rst (core_rst_b),
        .i_ld_start (i_ld_start),
        .i_ld_valid (i_ld_valid),
        .i_ld_data  (i_ld_data),
        .o_ld_ready (ready_b),
        .o_ld_err   (err_b),
        .o_state    (state_b)
    );

    nano_imem_loader #(.DEPTH(4)) u_small (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_pc       (i_pc),
        .o_inst     (inst_s),
        .o_core_rst (core_rst_s),
        .i_ld_start (i_ld_start),
        .i_ld_valid (i_ld_valid),
        .i_ld_data  (i_ld_data),
        .o_ld_ready (ready_s),
        .o_ld_err   (err_s),
        .o_state    (state_s)
    );

    // Stimulus helpers: inputs change 1 ns after the rising edge.
    task automatic send_byte(input logic [7:0] b);
        i_ld_valid = 1'b1;
        i_ld_data  = b;
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_len(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic pulse_start();
        i_ld_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_ld_start = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_pc = 32'd0; i_ld_start = 1'b0; i_ld_valid = 1'b0; i_ld_data = 8'd0;
        #3;
        n_checks++;
        if (state_b !== S_IDLE) begin $display("FAIL reset_state got %0d want %0d", state_b, S_IDLE); n_fail++; end
        n_checks++;
        if ({core_rst_b, ready_b, err_b} !== 3'b100) begin
            $display("FAIL reset_outputs got rst/rdy/err=%b want 100", {core_rst_b, ready_b, err_b}); n_fail++;
        end
        n_checks++;
        if (inst_b !== NOP) begin $display("FAIL reset_inst got %h want %h", inst_b, NOP); n_fail++; end
        @(posedge i_clk); #3;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        n_checks++;
        if ({state_b, ready_b} !== {S_IDLE, 1'b0}) begin
            $display("FAIL idle_hold got state=%0d rdy=%b want 0/0", state_b, ready_b); n_fail++;
        end
    endtask

    task automatic test_basic_load();
        pulse_start();
        n_checks++;
        if ({state_b, ready_b, core_rst_b} !== {S_LEN0, 1'b1, 1'b1}) begin
            $display("FAIL start_len0 got state=%0d rdy=%b rst=%b want 1/1/1", state_b, ready_b, core_rst_b); n_fail++;
        end
        i_pc = 32'd0;
        n_checks++;
        if (inst_b !== NOP) begin $display("FAIL nop_not_run got %h want %h", inst_b, NOP); n_fail++; end
        send_len(16'd2);
        n_checks++;
        if (state_b !== S_DATA) begin $display("FAIL basic_to_data got %0d want %0d", state_b, S_DATA); n_fail++; end
        // Back-to-back bytes, valid never drops.
        send_word(32'h0050_0013);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10);
        n_checks++;
        if ({state_b, core_rst_b} !== {S_DATA, 1'b1}) begin
            $display("FAIL basic_before_last got state=%0d rst=%b want 3/1", state_b, core_rst_b); n_fail++;
        end
        send_byte(8'h00);
        i_ld_valid = 1'b0;
        n_checks++;
        if ({state_b, core_rst_b, ready_b} !== {S_RUN, 1'b0, 1'b0}) begin
            $display("FAIL basic_run got state=%0d rst=%b rdy=%b want 4/0/0", state_b, core_rst_b, ready_b); n_fail++;
        end
        i_pc = 32'd0; #1;
        n_checks++;
        if (inst_b !== 32'h0050_0013) begin $display("FAIL basic_mem0 got %h want 00500013", inst_b); n_fail++; end
        i_pc = 32'd1; #1;
        n_checks++;
        if (inst_b !== 32'h0010_0093) begin $display("FAIL basic_mem1 got %h want 00100093", inst_b); n_fail++; end
    endtask

    task automatic test_ignore_in_run();
        send_word(32'hDEAD_BEEF);
        i_ld_valid = 1'b0;
        i_pc = 32'd0; #1;
        n_checks++;
        if ({state_b, inst_b} !== {S_RUN, 32'h0050_0013}) begin
            $display("FAIL run_ignores_bytes got state=%0d inst=%h want 4/00500013", state_b, inst_b); n_fail++;
        end
    endtask

    task automatic test_zero_len();
        pulse_start();
        send_len(16'd0);
        i_ld_valid = 1'b0;
        n_checks++;
        if ({state_b, core_rst_b} !== {S_RUN, 1'b0}) begin
            $display("FAIL zero_len_run got state=%0d rst=%b want 4/0", state_b, core_rst_b); n_fail++;
        end
        i_pc = 32'd0; #1;
        n_checks++;
        if (inst_b !== 32'h0050_0013) begin $display("FAIL zero_len_mem0 got %h want 00500013", inst_b); n_fail++; end
        i_pc = 32'd1; #1;
        n_checks++;
        if (inst_b !== 32'h0010_0093) begin $display("FAIL zero_len_mem1 got %h want 00100093", inst_b); n_fail++; end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        pulse_start();
        n_checks++;
        if ({state_b, core_rst_b} !== {S_LEN0, 1'b1}) begin
            $display("FAIL restart_from_run got state=%0d rst=%b want 1/1", state_b, core_rst_b); n_fail++;
        end
        send_len(16'd5);
        for (int k = 0; k < 4; k++) send_word(32'hA000_0000 | 32'(k));
        n_checks++;
        if ({state_s, err_s} !== {S_DATA, 1'b0}) begin
            $display("FAIL ovf_before got state=%0d err=%b want 3/0", state_s, err_s); n_fail++;
        end
        send_word(32'hA000_0004);
        i_ld_valid = 1'b0;
        n_checks++;
        if ({state_s, err_s, core_rst_s} !== {S_RUN, 1'b1, 1'b0}) begin
            $display("FAIL ovf_small got state=%0d err=%b rst=%b want 4/1/0", state_s, err_s, core_rst_s); n_fail++;
        end
        n_checks++;
        if ({state_b, err_b} !== {S_RUN, 1'b0}) begin
            $display("FAIL ovf_big got state=%0d err=%b want 4/0", state_b, err_b); n_fail++;
        end
        for (int k = 0; k < 4; k++) begin
            i_pc = 32'(k); #1;
            exp = 32'hA000_0000 | 32'(k);
            n_checks++;
            if (inst_s !== exp) begin $display("FAIL ovf_small_mem%0d got %h want %h", k, inst_s, exp); n_fail++; end
        end
        i_pc = 32'd4; #1;
        n_checks++;
        if (inst_s !== NOP) begin $display("FAIL ovf_small_pc4 got %h want %h", inst_s, NOP); n_fail++; end
        n_checks++;
        if (inst_b !== 32'hA000_0004) begin $display("FAIL ovf_big_mem4 got %h want a0000004", inst_b); n_fail++; end
        @(posedge i_clk); #1;
        n_checks++;
        if (err_s !== 1'b1) begin $display("FAIL ovf_sticky got %b want 1", err_s); n_fail++; end
    endtask

    task automatic test_restart();
        pulse_start();
        send_len(16'd2);
        send_byte(8'h11); send_byte(8'h22);
        // Start coincides with an accepted byte; the byte must be lost.
        i_ld_start = 1'b1;
        send_byte(8'h33);
        i_ld_start = 1'b0;
        i_ld_valid = 1'b0;
        n_checks++;
        if ({state_b, core_rst_b, ready_b} !== {S_LEN0, 1'b1, 1'b1}) begin
            $display("FAIL restart_len0 got state=%0d rst=%b rdy=%b want 1/1/1", state_b, core_rst_b, ready_b); n_fail++;
        end
        n_checks++;
        if (err_s !== 1'b0) begin $display("FAIL restart_err_clr got %b want 0", err_s); n_fail++; end
        send_len(16'd1);
        send_word(32'h1122_3344);
        i_ld_valid = 1'b0;
        i_pc = 32'd0; #1;
        n_checks++;
        if ({state_b, inst_b} !== {S_RUN, 32'h1122_3344}) begin
            $display("FAIL restart_mem0 got state=%0d inst=%h want 4/11223344", state_b, inst_b); n_fail++;
        end
        i_pc = 32'd1; #1;
        n_checks++;
        if (inst_b !== 32'hA000_0001) begin $display("FAIL restart_mem1_kept got %h want a0000001", inst_b); n_fail++; end
    endtask

    task automatic test_pc_range();
        i_pc = 32'd300; #1;
        n_checks++;
        if (inst_b !== NOP) begin $display("FAIL pc300 got %h want %h", inst_b, NOP); n_fail++; end
        i_pc = 32'd256; #1;
        n_checks++;
        if (inst_b !== NOP) begin $display("FAIL pc256 got %h want %h", inst_b, NOP); n_fail++; end
    endtask

    task automatic test_reset_mid_data();
        pulse_start();
        send_len(16'd1);
        send_byte(8'hEE); send_byte(8'hFF);
        i_ld_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({state_b, ready_b, core_rst_b, err_b} !== {S_IDLE, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL async_reset got state=%0d rdy=%b rst=%b err=%b want 0/0/1/0", state_b, ready_b, core_rst_b, err_b); n_fail++;
        end
        #3;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        pulse_start();
        send_len(16'd0);
        i_ld_valid = 1'b0;
        i_pc = 32'd0; #1;
        n_checks++;
        if ({state_b, inst_b} !== {S_RUN, 32'h1122_3344}) begin
            $display("FAIL reset_abort_mem0 got state=%0d inst=%h want 4/11223344", state_b, inst_b); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_ignore_in_run();
        test_zero_len();
        test_overflow();
        test_restart();
        test_pc_range();
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
